// File: rtl/rnn_pkg.sv
// rnn_pkg: sequencer state encoding, rnn register map and default widths
package rnn_pkg;
  localparam int RNN_EMB_BITS = 2;
  localparam int RNN_BITS = 16;
  localparam logic [2:0] RNN_A_START = 3'd0;
  localparam logic [2:0] RNN_A_INPUT = 3'd1;
  localparam logic [2:0] RNN_A_DENSE_RES = 3'd7;
  typedef enum logic [3:0] {
    SYNC, DRAIN, IDLE, LOADIN, STEP, STEPW, DENSE, VALW, RDRES, OUT, CLRW
  } state_t;
endpackage

// File: rtl/rnn_poll_timer.sv
// rnn_poll_timer: watchdog counting cycles spent in the current poll state (built only with RNN_SEQ_TIMEOUT_EN)
`ifdef RNN_SEQ_TIMEOUT_EN
module rnn_poll_timer import rnn_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t st,
  input  logic   en,
  output logic   expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
  state_t st_q;
  logic [W-1:0] cnt, cur;
  assign cur = (st != st_q) ? '0 : cnt;
  assign expired = en && cur == W'(TIMEOUT_CYCLES - 1);
  // restart on every state change and after each expiry so SYNC can re-arm itself
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= SYNC;
      cnt <= '0;
    end else begin
      st_q <= st;
      cnt <= (en && !expired) ? cur + 1'b1 : '0;
    end
  end
endmodule
`endif

// File: rtl/rnn_seq_ctrl.sv
// rnn_seq_ctrl: streams one char sequence through rnn and returns the dense result; RNN_SEQ_TIMEOUT_EN adds a poll watchdog
module rnn_seq_ctrl import rnn_pkg::*; #(
  parameter int EMB_BITS = RNN_EMB_BITS,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RNN_BITS-1:0] in_data,
  input  logic                in_last,
  output logic                m_read,
  output logic                m_write,
  output logic [2:0]          m_addr,
  output logic [31:0]         m_wdata,
  input  logic [31:0]         m_rdata,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RNN_BITS-1:0] res_data,
  output logic                res_pos,
  output logic [15:0]         chars_done,
  output logic                err
);
  state_t state;
  logic [EMB_BITS-1:0] elem_idx;
  logic last_q, sync_ph, tmo, rd_done, unused_rdata;
  logic [2:0] addr_sel;
  assign rd_done = m_rdata[0];
  assign unused_rdata = ^m_rdata[31:16];
  assign in_ready = rst_n && state == LOADIN;
  assign m_write = rst_n && ((state == LOADIN && in_valid) || state == STEP || state == DENSE);
  assign m_read = rst_n && (state inside {SYNC, DRAIN, STEPW, VALW, RDRES, CLRW});
  assign addr_sel = (state == SYNC) ? (sync_ph ? RNN_A_START : RNN_A_INPUT) :
                    (state inside {LOADIN, STEPW, CLRW}) ? RNN_A_INPUT :
                    (state inside {DRAIN, DENSE, RDRES}) ? RNN_A_DENSE_RES : RNN_A_START;
  assign m_addr = (m_read || m_write) ? addr_sel : '0;
  assign m_wdata = m_write ? {8'h00, 8'(elem_idx), (state == LOADIN) ? in_data : 16'h0001} : '0;
`ifdef RNN_SEQ_TIMEOUT_EN
  rnn_poll_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .st(state),
    .en(state inside {SYNC, STEPW, VALW, CLRW}),
    .expired(tmo)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  // sequencer FSM; a watchdog expiry overrides every state and forces a resync
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SYNC;
      elem_idx <= '0;
      last_q <= 1'b0;
      sync_ph <= 1'b0;
      chars_done <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_pos <= 1'b0;
      err <= 1'b0;
    end else if (tmo) begin
      state <= SYNC;
      sync_ph <= 1'b0;
      res_valid <= 1'b0;
      err <= 1'b1;
    end else begin
      case (state)
        SYNC: begin
          sync_ph <= !sync_ph;
          if (rd_done) begin
            sync_ph <= 1'b0;
            state <= sync_ph ? DRAIN : IDLE;
          end
        end
        DRAIN: state <= CLRW;
        IDLE: if (in_valid) begin
          chars_done <= '0;
          state <= LOADIN;
        end
        LOADIN: if (in_valid) begin
          elem_idx <= elem_idx + 1'b1;
          if (&elem_idx) begin
            last_q <= in_last;
            state <= STEP;
          end
        end
        STEP: begin
          chars_done <= chars_done + {15'd0, ~&chars_done};
          state <= STEPW;
        end
        STEPW: if (rd_done) state <= last_q ? DENSE : LOADIN;
        DENSE: state <= VALW;
        VALW: if (rd_done) state <= RDRES;
        RDRES: begin
          res_data <= m_rdata[15:0];
          res_pos <= ~m_rdata[15];
          res_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (res_ready) begin
          res_valid <= 1'b0;
          state <= CLRW;
        end
        CLRW: if (rd_done) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// tb_rnn_seq_ctrl: directed bench with a behavioural rnn slave; define RNN_SEQ_TIMEOUT_EN to also exercise the watchdog
module tb_rnn_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0, stuck = 1'b0;
  logic in_ready, m_read, m_write, res_valid, res_pos, err;
  logic [15:0] in_data = '0, res_data, chars_done, h = '0;
  logic [2:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [15:0] x [4] = '{default: 16'h0000};
  localparam int M_IDLE = 0, M_START = 1, M_BUSY = 2, M_DBUSY = 3, M_VALID = 4, M_CLEAR = 5;
  int mst = M_IDLE, mcnt = 0;
  int n_cmp = 0, n_bad = 0;
  int wr0 = 0, wr1 = 0, wr7 = 0, rd0 = 0, rd1 = 0, rd7 = 0, sel_err = 0, both = 0, idle_junk = 0, wr0_at_dense = 0;

  always #5 clk = ~clk;

  rnn_seq_ctrl #(.EMB_BITS(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_pos(res_pos), .chars_done(chars_done), .err(err)
  );

  // rnn slave: addr1 reads report idle, addr0 reads report dense-valid, addr7 returns the hidden sum
  assign m_rdata = (m_addr == 3'd1) ? {31'd0, mst == M_IDLE} :
                   (m_addr == 3'd0) ? {31'd0, mst == M_VALID} :
                   (m_addr == 3'd7) ? {16'd0, h} : 32'd0;

  always @(posedge clk) begin
    if (m_read && m_write) both <= both + 1;
    if (!m_read && !m_write && (m_addr != 3'd0 || m_wdata != 32'd0)) idle_junk <= idle_junk + 1;
    case (mst)
      M_START: begin mst <= M_BUSY; mcnt <= 2; end
      M_BUSY: if (!stuck) begin if (mcnt == 0) mst <= M_IDLE; else mcnt <= mcnt - 1; end
      M_DBUSY: if (mcnt == 0) mst <= M_VALID; else mcnt <= mcnt - 1;
      M_CLEAR: if (mcnt == 0) mst <= M_IDLE; else mcnt <= mcnt - 1;
      default: ;
    endcase
    if (m_write) begin
      case (m_addr)
        3'd1: begin
          wr1 <= wr1 + 1;
          x[m_wdata[17:16]] <= m_wdata[15:0];
          if (m_wdata[23:16] != 8'(wr1 % 4)) sel_err <= sel_err + 1;
        end
        3'd0: begin wr0 <= wr0 + 1; h <= h + x[0] + x[1] + x[2] + x[3]; mst <= M_START; end
        3'd7: begin wr7 <= wr7 + 1; wr0_at_dense <= wr0; mst <= M_DBUSY; mcnt <= 2; end
        default: ;
      endcase
    end
    if (m_read) begin
      case (m_addr)
        3'd0: rd0 <= rd0 + 1;
        3'd1: rd1 <= rd1 + 1;
        3'd7: begin
          rd7 <= rd7 + 1;
          if (mst == M_VALID) begin h <= '0; mst <= M_CLEAR; mcnt <= 2; end
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [15:0] d0, d1, d2, d3, input int last_at, input int gap);
    logic [15:0] d [4];
    int n;
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      tick(gap);
      @(negedge clk);
      in_valid = 1'b1; in_data = d[i]; in_last = (i == last_at);
      n = 0;
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) check("elem_accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    end
  endtask

  task automatic wait_res(input string tag, input logic [15:0] ed, input logic ep, input logic [15:0] ec);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 500) begin @(negedge clk); n++; end
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_res_data"}, 32'(res_data), 32'(ed));
    check({tag, "_res_pos"}, 32'(res_pos), 32'(ep));
    check({tag, "_chars_done"}, 32'(chars_done), 32'(ec));
  endtask

  task automatic ack;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    int s_wr0, s_wr1, s_wr7, s_rd0, s_rd1, s_rd7, s_acc, bad, n;
    tick(3);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_chars_done", 32'(chars_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("sync_rd1", 32'(rd1), 32'd1);

    // one char, last on element 3
    s_wr0 = wr0; s_wr1 = wr1; s_wr7 = wr7; s_rd0 = rd0; s_rd1 = rd1; s_rd7 = rd7;
    send_char(16'h0100, 16'h0080, 16'h0000, 16'hFF00, 3, 0);
    wait_res("t1", 16'h0080, 1'b1, 16'd1);
    check("t1_wr1", 32'(wr1 - s_wr1), 32'd4);
    check("t1_wr0", 32'(wr0 - s_wr0), 32'd1);
    check("t1_wr7", 32'(wr7 - s_wr7), 32'd1);
    check("t1_stepw_polls", 32'(rd1 - s_rd1), 32'd5);
    check("t1_valw_polls", 32'(rd0 - s_rd0), 32'd4);
    check("t1_rd7", 32'(rd7 - s_rd7), 32'd1);
    ack;
    s_rd1 = rd1;
    tick(10);
    check("t1_clrw_polls", 32'(rd1 - s_rd1), 32'd3);
    check("t1_res_valid_low", 32'(res_valid), 32'd0);

    // three chars with in_valid gaps
    s_wr0 = wr0; s_wr1 = wr1; s_wr7 = wr7;
    send_char(16'h0010, 16'h0020, 16'h0030, 16'h0040, 4, 2);
    send_char(16'h0100, 16'h0000, 16'h0000, 16'h0000, 4, 1);
    send_char(16'hFE00, 16'h0000, 16'h0000, 16'h0000, 3, 3);
    wait_res("t2", 16'hFFA0, 1'b0, 16'd3);
    check("t2_wr1", 32'(wr1 - s_wr1), 32'd12);
    check("t2_wr0", 32'(wr0 - s_wr0), 32'd3);
    check("t2_wr7", 32'(wr7 - s_wr7), 32'd1);
    check("t2_dense_after_step3", 32'(wr0_at_dense - s_wr0), 32'd3);
    ack;
    tick(10);

    // consumer back-pressure
    send_char(16'h0200, 16'h0000, 16'h0000, 16'h0001, 3, 0);
    wait_res("t3", 16'h0201, 1'b1, 16'd1);
    s_acc = wr0 + wr1 + wr7 + rd0 + rd1 + rd7;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 16'h0201) bad++;
    end
    check("t3_hold_stable", 32'(bad), 32'd0);
    check("t3_no_access", 32'(wr0 + wr1 + wr7 + rd0 + rd1 + rd7 - s_acc), 32'd0);
    ack;
    s_rd1 = rd1; s_acc = wr0 + wr1 + wr7 + rd0 + rd1 + rd7;
    tick(10);
    check("t3_clrw_polls", 32'(rd1 - s_rd1), 32'd1);
    check("t3_clrw_only", 32'(wr0 + wr1 + wr7 + rd0 + rd1 + rd7 - s_acc), 32'd1);

    // controller-only reset while rnn finishes the dense layer
    s_wr7 = wr7;
    send_char(16'h0300, 16'h0000, 16'h0000, 16'h0000, 3, 0);
    n = 0;
    while (wr7 == s_wr7 && n < 200) begin @(negedge clk); n++; end
    check("t4_dense_written", 32'(wr7 - s_wr7), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_chars_done", 32'(chars_done), 32'd0);
    check("t4_rst_res_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    s_wr0 = wr0; s_wr1 = wr1; s_wr7 = wr7; s_rd0 = rd0; s_rd1 = rd1; s_rd7 = rd7;
    tick(20);
    check("t4_drain_rd7", 32'(rd7 - s_rd7), 32'd1);
    check("t4_sync_rd0", 32'(rd0 - s_rd0), 32'd2);
    check("t4_sync_clrw_rd1", 32'(rd1 - s_rd1), 32'd6);
    check("t4_no_writes", 32'(wr0 + wr1 + wr7 - s_wr0 - s_wr1 - s_wr7), 32'd0);
    send_char(16'h0040, 16'h0040, 16'h0000, 16'h0000, 3, 0);
    wait_res("t4", 16'h0080, 1'b1, 16'd1);
    ack;
    tick(10);

    // in_last on a non-final element is ignored
    s_wr0 = wr0; s_wr7 = wr7;
    send_char(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1, 0);
    send_char(16'h0010, 16'h0000, 16'h0000, 16'h0000, 3, 0);
    wait_res("t6", 16'h001A, 1'b1, 16'd2);
    check("t6_wr0", 32'(wr0 - s_wr0), 32'd2);
    check("t6_wr7", 32'(wr7 - s_wr7), 32'd1);
    ack;
    tick(10);

`ifdef RNN_SEQ_TIMEOUT_EN
    // rnn stuck busy: watchdog fires on the 16th poll
    stuck = 1'b1;
    s_wr0 = wr0;
    send_char(16'h0001, 16'h0000, 16'h0000, 16'h0000, 3, 0);
    n = 0;
    while (wr0 == s_wr0 && n < 50) begin @(negedge clk); n++; end
    s_rd1 = rd1;
    n = 0;
    while (!err && n < 100) begin @(negedge clk); n++; end
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_polls_at_err", 32'(rd1 - s_rd1), 32'd16);
    check("t5_res_valid", 32'(res_valid), 32'd0);
    tick(40);
    check("t5_err_sticky_sync", 32'(err), 32'd1);
    stuck = 1'b0;
    tick(10);
    send_char(16'h0005, 16'h0000, 16'h0000, 16'h0000, 3, 0);
    wait_res("t5", 16'h0006, 1'b1, 16'd1);
    ack;
    tick(10);
    check("t5_err_sticky_end", 32'(err), 32'd1);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    check("strobe_exclusive", 32'(both), 32'd0);
    check("idle_bus_zero", 32'(idle_junk), 32'd0);
    check("input_sel_order", 32'(sel_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
